// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and sizes for the data-memory port arbiter
package dmem_pkg;
    localparam int AW_DEF = 11;
    localparam int DW_DEF = 16;
    localparam int BLEN_W = 2;
    typedef enum logic [1:0] {IDLE, SERVE_A, SERVE_B} state_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_A, TAG_B} tag_t;
endpackage

// File: rtl/burst_counter.sv
// burst_counter: burst address (wrapping) and remaining-beat count for port B
module burst_counter import dmem_pkg::*; #(
    parameter int AW = AW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [AW-1:0]     start,
    input  logic [BLEN_W-1:0] len,
    output logic [AW-1:0]     addr,
    output logic              last
);
    logic [BLEN_W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
            cnt  <= '0;
        end else if (load) begin
            addr <= start;
            cnt  <= len;
        end else if (step) begin
            addr <= addr + 1'b1;
            cnt  <= cnt - 1'b1;
        end
    end
    assign last = (cnt == '0);
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single-port data memory between the pipeline (A)
// and the interrupt/stack burst engine (B), tagging read returns to their owner
module dmem_port_arbiter import dmem_pkg::*; #(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [AW-1:0]     a_addr,
    input  logic [DW-1:0]     a_wdata,
    output logic              a_gnt,
    output logic              a_stall,
    output logic              a_rvalid,
    output logic [DW-1:0]     a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [AW-1:0]     b_addr,
    input  logic [BLEN_W-1:0] b_len,
    input  logic [DW-1:0]     b_wdata,
    output logic              b_gnt,
    output logic              b_beat,
    output logic              b_rvalid,
    output logic [DW-1:0]     b_rdata,
    output logic              b_done,
    output logic              mem_read,
    output logic              mem_write,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata
);
    state_t state, state_nx;
    tag_t tag;
    logic last_b, a_we_q, b_we_q, b_last;
    logic arb, pick_b, burst_more, rd_nx, wr_nx;
    logic [AW-1:0] a_addr_q, b_addr_cur;
    logic [DW-1:0] a_wdata_q;

    burst_counter #(.AW(AW)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (b_gnt),
        .step  (b_beat),
        .start (b_addr),
        .len   (b_len),
        .addr  (b_addr_cur),
        .last  (b_last)
    );

    // grants are withheld while reset is held so every output reads 0
    always_comb begin
        arb        = rst_n && (state != SERVE_B);
        pick_b     = b_req && (!a_req || !last_b);
        b_gnt      = arb && pick_b;
        a_gnt      = arb && a_req && !pick_b;
        burst_more = (state == SERVE_B) && !b_last;
        state_nx   = b_gnt ? SERVE_B : a_gnt ? SERVE_A : burst_more ? SERVE_B : IDLE;
        rd_nx      = b_gnt ? !b_we : a_gnt ? !a_we : burst_more && !b_we_q;
        wr_nx      = b_gnt ? b_we : a_gnt ? a_we : burst_more && b_we_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tag       <= TAG_NONE;
            last_b    <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            a_we_q    <= 1'b0;
            a_addr_q  <= '0;
            a_wdata_q <= '0;
            b_we_q    <= 1'b0;
        end else begin
            state     <= state_nx;
            mem_read  <= rd_nx;
            mem_write <= wr_nx;
            tag       <= !mem_read ? TAG_NONE : (state == SERVE_A ? TAG_A : TAG_B);
            if (arb && a_req && b_req) last_b <= pick_b;
            if (a_gnt) begin
                a_we_q    <= a_we;
                a_addr_q  <= a_addr;
                a_wdata_q <= a_wdata;
            end
            if (b_gnt) b_we_q <= b_we;
        end
    end

    assign a_stall   = rst_n && a_req && !a_gnt;
    assign b_beat    = (state == SERVE_B);
    assign b_done    = b_beat && b_last;
    assign a_rvalid  = (tag == TAG_A);
    assign b_rvalid  = (tag == TAG_B);
    assign a_rdata   = a_rvalid ? mem_rdata : '0;
    assign b_rdata   = b_rvalid ? mem_rdata : '0;
    assign mem_addr  = (state == SERVE_A) ? a_addr_q : b_beat ? b_addr_cur : '0;
    assign mem_wdata = (state == SERVE_A) ? a_wdata_q : b_beat ? b_wdata : '0;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed cycle-by-cycle checks of the data-memory arbiter
module tb_dmem_port_arbiter;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [10:0] a_addr = 0, b_addr = 0;
    logic [15:0] a_wdata = 0, b_wdata = 0;
    logic [1:0]  b_len = 0;
    logic        a_gnt, a_stall, a_rvalid, b_gnt, b_beat, b_rvalid, b_done, mem_read, mem_write;
    logic [15:0] a_rdata, b_rdata, mem_wdata;
    logic [15:0] mem_rdata = 0;
    logic [10:0] mem_addr;
    logic [15:0] mem [0:2047];
    int pass_cnt = 0, total = 0;

    localparam logic [8:0] AG = 9'h100, AS = 9'h080, AV = 9'h040, BG = 9'h020, BB = 9'h010,
                           BV = 9'h008, BD = 9'h004, MR = 9'h002, MW = 9'h001;

    dmem_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_stall(a_stall), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_len(b_len), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_beat(b_beat), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_done(b_done),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // memory model: preloaded while reset is held, read data one cycle after the strobe
    always @(posedge clk) begin
        if (!rst_n) begin
            mem[5] <= 16'h1234;
            mem[11'h020] <= 16'hC0DE;
            for (int k = 0; k < 4; k++) begin
                mem[11'h100 + 11'(k)] <= 16'h00B0 + 16'(k);
                mem[11'h200 + 11'(k)] <= 16'h00D0 + 16'(k);
            end
            mem_rdata <= '0;
        end else begin
            if (mem_write) mem[mem_addr] <= mem_wdata;
            if (mem_read) mem_rdata <= mem[mem_addr];
        end
    end

    function automatic logic [8:0] sig();
        return {a_gnt, a_stall, a_rvalid, b_gnt, b_beat, b_rvalid, b_done, mem_read, mem_write};
    endfunction

    task automatic do_reset();
        rst_n = 0; a_req = 0; b_req = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0; a_req = 1; b_req = 1;
        repeat (2) @(posedge clk);
        #4;
        total++;
        if ({sig(), mem_addr} !== 20'h0) $display("FAIL reset_hold: sig=%b addr=%h want 0", sig(), mem_addr);
        else pass_cnt++;
        a_req = 0; b_req = 0;
        @(posedge clk); #1 rst_n = 1; #4;
        total++;
        if (sig() !== 9'h0) $display("FAIL reset_release: sig=%b want 0", sig());
        else pass_cnt++;
    endtask

    task automatic a_read(input logic [10:0] addr, input logic [15:0] exp);
        @(posedge clk); #1; a_req = 1; a_we = 0; a_addr = addr; a_wdata = 0; #4;
        total++;
        if (sig() !== AG) $display("FAIL a_read_gnt %h: sig=%b want %b", addr, sig(), AG);
        else pass_cnt++;
        @(posedge clk); #1; a_req = 0; #4;
        total++;
        if ({sig(), mem_addr} !== {MR, addr}) $display("FAIL a_read_strobe %h: sig=%b addr=%h want %b %h", addr, sig(), mem_addr, MR, addr);
        else pass_cnt++;
        @(posedge clk); #5;
        total++;
        if ({sig(), a_rdata} !== {AV, exp}) $display("FAIL a_read_data %h: sig=%b data=%h want %b %h", addr, sig(), a_rdata, AV, exp);
        else pass_cnt++;
    endtask

    task automatic test_b_write();
        logic [8:0]  es [6] = '{BG, BB|MW, BB|MW, BB|MW, BB|MW|BD, 9'h0};
        logic [10:0] ea [6] = '{11'h000, 11'h7FE, 11'h7FF, 11'h000, 11'h001, 11'h000};
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin b_req = 1; b_we = 1; b_addr = 11'h7FE; b_len = 3; end
            else begin b_req = 0; b_wdata = 16'h00A0 + 16'(i - 1); end
            #4;
            total++;
            if ({sig(), mem_addr} !== {es[i], ea[i]}) $display("FAIL b_write c%0d: sig=%b addr=%h want %b %h", i, sig(), mem_addr, es[i], ea[i]);
            else pass_cnt++;
        end
        a_read(11'h7FE, 16'h00A0);
        a_read(11'h7FF, 16'h00A1);
        a_read(11'h000, 16'h00A2);
        a_read(11'h001, 16'h00A3);
    endtask

    task automatic test_conflict();
        logic [8:0]  es [7] = '{BG|AS, BB|BD|MR|AS, AG|BV, AG|MW, BG|MR, BB|BD|MW|AV, 9'h0};
        logic [10:0] ea [7] = '{11'h0, 11'h020, 11'h0, 11'h00A, 11'h005, 11'h030, 11'h0};
        logic [15:0] ead [7] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h1234, 16'h0};
        logic [15:0] ebd [7] = '{16'h0, 16'h0, 16'hC0DE, 16'h0, 16'h0, 16'h0, 16'h0};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            case (i)
                0: begin a_req = 1; a_we = 1; a_addr = 11'h00A; a_wdata = 16'h0055;
                         b_req = 1; b_we = 0; b_addr = 11'h020; b_len = 0; end
                1: b_req = 0;
                3: begin a_we = 0; a_addr = 11'h005; a_wdata = 0;
                         b_req = 1; b_we = 1; b_addr = 11'h030; b_len = 0; end
                4: a_req = 0;
                5: begin b_req = 0; b_wdata = 16'h0077; end
                default: ;
            endcase
            #4;
            total++;
            if ({sig(), mem_addr, a_rdata, b_rdata} !== {es[i], ea[i], ead[i], ebd[i]})
                $display("FAIL conflict c%0d: sig=%b addr=%h ad=%h bd=%h want %b %h %h %h",
                         i, sig(), mem_addr, a_rdata, b_rdata, es[i], ea[i], ead[i], ebd[i]);
            else pass_cnt++;
        end
        total++;
        if ({mem[11'h00A], mem[11'h030]} !== {16'h0055, 16'h0077})
            $display("FAIL conflict_mem: got %h %h want 0055 0077", mem[11'h00A], mem[11'h030]);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        logic [8:0]  es [7] = '{BG, BB|MR|AS, BB|MR|AS|BV, BB|BD|MR|AS|BV, AG|BV, MR, AV};
        logic [10:0] ea [7] = '{11'h0, 11'h100, 11'h101, 11'h102, 11'h0, 11'h005, 11'h0};
        logic [15:0] ead [7] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h1234};
        logic [15:0] ebd [7] = '{16'h0, 16'h0, 16'h00B0, 16'h00B1, 16'h00B2, 16'h0, 16'h0};
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            case (i)
                0: begin b_req = 1; b_we = 0; b_addr = 11'h100; b_len = 2; end
                1: begin b_req = 0; a_req = 1; a_we = 0; a_addr = 11'h005; end
                5: a_req = 0;
                default: ;
            endcase
            #4;
            total++;
            if ({sig(), mem_addr, a_rdata, b_rdata} !== {es[i], ea[i], ead[i], ebd[i]})
                $display("FAIL stall c%0d: sig=%b addr=%h ad=%h bd=%h want %b %h %h %h",
                         i, sig(), mem_addr, a_rdata, b_rdata, es[i], ea[i], ead[i], ebd[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0]  es [5] = '{AG, AG|MW, AG|MW, MW, 9'h0};
        logic [10:0] ea [5] = '{11'h0, 11'h001, 11'h002, 11'h003, 11'h0};
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (i < 3) begin
                a_req = 1; a_we = 1; a_addr = 11'(i + 1); a_wdata = 16'h0011 * 16'(i + 1);
            end else a_req = 0;
            #4;
            total++;
            if ({sig(), mem_addr} !== {es[i], ea[i]}) $display("FAIL b2b c%0d: sig=%b addr=%h want %b %h", i, sig(), mem_addr, es[i], ea[i]);
            else pass_cnt++;
        end
        total++;
        if ({mem[1], mem[2], mem[3]} !== {16'h0011, 16'h0022, 16'h0033})
            $display("FAIL b2b_mem: got %h %h %h want 0011 0022 0033", mem[1], mem[2], mem[3]);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_burst();
        logic [8:0]  es [3] = '{BG, BB|MR, BB|MR|BV};
        logic [10:0] ea [3] = '{11'h0, 11'h200, 11'h201};
        logic [15:0] ebd [3] = '{16'h0, 16'h0, 16'h00D0};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin b_req = 1; b_we = 0; b_addr = 11'h200; b_len = 3; end
            else b_req = 0;
            #4;
            total++;
            if ({sig(), mem_addr, b_rdata} !== {es[i], ea[i], ebd[i]})
                $display("FAIL mid_rst c%0d: sig=%b addr=%h bd=%h want %b %h %h", i, sig(), mem_addr, b_rdata, es[i], ea[i], ebd[i]);
            else pass_cnt++;
        end
        @(posedge clk); #1 rst_n = 0; #1;
        total++;
        if ({sig(), mem_addr, b_rdata} !== 36'h0) $display("FAIL mid_rst_drop: sig=%b addr=%h bd=%h want 0", sig(), mem_addr, b_rdata);
        else pass_cnt++;
        @(posedge clk); #1 rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            #4;
            total++;
            if (sig() !== 9'h0) $display("FAIL mid_rst_after c%0d: sig=%b want 0", i, sig());
            else pass_cnt++;
            @(posedge clk); #1;
        end
        a_read(11'h005, 16'h1234);
    endtask

    initial begin
        test_reset();
        a_read(11'h005, 16'h1234);
        test_b_write();
        test_conflict();
        test_stall();
        test_back_to_back();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
